// File: rtl/stream_chunker_if.sv
// Stream interface for stream_chunker. The producer and consumer side is the
// master and the chunker is the slave.
interface stream_chunker_if #(
    parameter int DATA_BYTES = 4
);
    localparam int DATA_BITS = DATA_BYTES * 8;
    localparam int CNT_BITS  = $clog2(DATA_BYTES);

    logic [DATA_BITS-1:0] in_data;
    logic [CNT_BITS-1:0]  in_cnt;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;

    logic [CNT_BITS-1:0]  req_cnt;
    logic [DATA_BITS-1:0] out_data;
    logic [CNT_BITS-1:0]  out_cnt;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_cnt, in_last, in_valid, req_cnt, out_ready,
        input  in_ready, out_data, out_cnt, out_last, out_valid
    );

    modport slave (
        input  in_data, in_cnt, in_last, in_valid, req_cnt, out_ready,
        output in_ready, out_data, out_cnt, out_last, out_valid
    );
endinterface

// File: rtl/stream_chunker.sv
// Re-chunks a normalized byte stream into consumer-sized pieces. A 2-beat byte
// buffer is drained from the front by a funnel shifter and refilled at its tail.
module stream_chunker #(
    parameter int DATA_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_chunker_if.slave bus
);
    localparam int CNT_BITS  = $clog2(DATA_BYTES);
    localparam int CW        = CNT_BITS + 2;
    localparam int IW        = CNT_BITS + 1;
    localparam int BUF_BYTES = 2 * DATA_BYTES;

    logic [7:0]    buf_q [BUF_BYTES];
    logic [7:0]    buf_d [BUF_BYTES];
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic          last_held_q, last_held_d;

    logic [CW-1:0] req_bytes, chunk_bytes, in_bytes, kept_bytes, shift_bytes;
    logic [CW-1:0] src, rel;
    logic          in_fire, out_fire;

    always_comb begin
        req_bytes   = (bus.req_cnt == '0) ? CW'(DATA_BYTES) : CW'(bus.req_cnt);
        in_bytes    = (bus.in_cnt == '0) ? CW'(DATA_BYTES) : CW'(bus.in_cnt);
        chunk_bytes = (buf_cnt_q < req_bytes) ? buf_cnt_q : req_bytes;
    end

    // Handshake outputs depend on registered state (plus req_cnt on the read side).
    assign bus.in_ready  = !last_held_q && (buf_cnt_q <= CW'(DATA_BYTES));
    assign bus.out_valid = (buf_cnt_q >= req_bytes) || (last_held_q && (buf_cnt_q != '0));
    assign bus.out_last  = last_held_q && (buf_cnt_q <= req_bytes);
    assign bus.out_cnt   = chunk_bytes[CNT_BITS-1:0];

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            bus.out_data[8*i +: 8] = (CW'(i) < chunk_bytes) ? buf_q[i] : 8'h00;
        end
    end

    // Drop the consumed chunk first, then insert the new beat right after the survivors.
    always_comb begin
        shift_bytes = out_fire ? chunk_bytes : '0;
        kept_bytes  = buf_cnt_q - shift_bytes;
        src         = '0;
        rel         = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            src      = CW'(i) + shift_bytes;
            buf_d[i] = (src < CW'(BUF_BYTES)) ? buf_q[src[IW-1:0]] : 8'h00;
            rel      = CW'(i) - kept_bytes;
            if (in_fire && (CW'(i) >= kept_bytes) && (rel < in_bytes)) begin
                buf_d[i] = bus.in_data[{rel[CNT_BITS-1:0], 3'b000} +: 8];
            end
        end
        buf_cnt_d   = kept_bytes + (in_fire ? in_bytes : '0);
        last_held_d = (last_held_q && !(out_fire && bus.out_last)) || (in_fire && bus.in_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_cnt_q   <= '0;
            last_held_q <= 1'b0;
        end else begin
            buf_cnt_q   <= buf_cnt_d;
            last_held_q <= last_held_d;
        end
    end

    // Byte contents beyond buf_cnt are never observed, so they need no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_stream_chunker.sv
// Self-checking bench for stream_chunker: a byte-queue model is compared with
// the DUT every cycle, and directed packets pin the model with literal chunks.
module tb_stream_chunker;
    localparam int DB = 4;
    localparam int CB = $clog2(DB);
    localparam int DW = DB * 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [CB-1:0] cnt;
        bit            last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_chunker_if #(.DATA_BYTES(DB)) bus();
    stream_chunker #(.DATA_BYTES(DB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    beat_t         beatQ[$];
    beat_t         chunkLog[$];
    byte unsigned  mq[$];
    bit            mLast = 1'b0;
    int            nChecks = 0;
    int            nFail = 0;

    logic [DW-1:0] expData;
    logic [CB-1:0] expCnt;
    bit            expVld, expLast, expRdy;
    int            expK;
    bit            lastInFire = 1'b0;
    bit            prevStall = 1'b0;

    // Expected outputs from the queued bytes and the current request size.
    function automatic void computeExpected();
        int r = (bus.req_cnt == 0) ? DB : int'(bus.req_cnt);
        int sz = mq.size();
        expK    = (r < sz) ? r : sz;
        expData = '0;
        for (int i = 0; i < expK; i++) expData[8*i +: 8] = mq[i];
        expCnt  = CB'(expK % DB);
        expVld  = (sz >= r) || (mLast && sz != 0);
        expLast = mLast && (sz <= r);
        expRdy  = !mLast && (sz <= DB);
    endfunction

    task automatic checkField(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        computeExpected();
        checkField("in_ready", bus.in_ready, expRdy);
        checkField("out_valid", bus.out_valid, expVld);
        checkField("out_data", bus.out_data, expData);
        checkField("out_cnt", bus.out_cnt, expCnt);
        checkField("out_last", bus.out_last, expLast);
    endtask

    // One clock cycle: check at mid-cycle, advance the model at the active edge.
    task automatic step();
        bit inFire, outFire;
        int e;
        #1;
        checkOutput();
        inFire  = bus.in_valid && expRdy;
        outFire = expVld && bus.out_ready;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            mLast = 1'b0;
        end else begin
            if (outFire) begin
                chunkLog.push_back('{expData, expCnt, expLast});
                repeat (expK) void'(mq.pop_front());
                if (expLast) mLast = 1'b0;
            end
            if (inFire) begin
                e = (bus.in_cnt == 0) ? DB : int'(bus.in_cnt);
                for (int j = 0; j < e; j++) mq.push_back(bus.in_data[8*j +: 8]);
                if (bus.in_last) mLast = 1'b1;
            end
        end
        lastInFire = rst_n && inFire;
        prevStall  = expVld && !bus.out_ready;
        @(negedge clk);
    endtask

    function automatic void pushBeat(input logic [DW-1:0] d, input int c, input bit l);
        beatQ.push_back('{d, CB'(c), l});
    endfunction

    task automatic applyStimulus(input int pIn, input int pOut, input int reqMode,
                                 input int maxCycles, input bit expectDrain, output int cycles);
        bit offering = 1'b0;
        bit done = 1'b0;
        cycles = 0;
        while (!done && cycles < maxCycles) begin
            if (expectDrain && beatQ.size() == 0 && mq.size() == 0 && !mLast) begin
                done = 1'b1;
            end else begin
                if (!offering && beatQ.size() > 0 && ($urandom % 100) < pIn) offering = 1'b1;
                bus.in_valid = offering;
                if (offering) begin
                    bus.in_data = beatQ[0].data;
                    bus.in_cnt  = beatQ[0].cnt;
                    bus.in_last = beatQ[0].last;
                end
                bus.out_ready = (($urandom % 100) < pOut);
                if (!prevStall) bus.req_cnt = (reqMode < 0) ? CB'($urandom_range(0, DB - 1)) : CB'(reqMode);
                step();
                if (lastInFire) begin
                    void'(beatQ.pop_front());
                    offering = 1'b0;
                end
                cycles++;
            end
        end
        if (expectDrain && !(beatQ.size() == 0 && mq.size() == 0 && !mLast)) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL drain timeout: actual=%0d cycles, required=drained within %0d", cycles, maxCycles);
        end
    endtask

    task automatic checkChunk(input string name, input int idx, input logic [DW-1:0] d,
                              input int c, input bit l);
        if (chunkLog.size() <= idx) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s missing: actual=%0d chunks, required>%0d", name, chunkLog.size(), idx);
        end else begin
            checkField({name, " data"}, chunkLog[idx].data, d);
            checkField({name, " cnt"}, chunkLog[idx].cnt, c);
            checkField({name, " last"}, chunkLog[idx].last, l);
        end
    endtask

    initial begin
        int cyc;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_cnt = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0; bus.req_cnt = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        #1;
        checkField("reset in_ready", bus.in_ready, 1);
        checkField("reset out_valid", bus.out_valid, 0);
        checkField("reset out_data", bus.out_data, 0);
        checkField("reset out_cnt", bus.out_cnt, 0);
        checkField("reset out_last", bus.out_last, 0);
        rst_n = 1'b1;

        $display("[TB] req 3 across two beats");
        chunkLog.delete();
        pushBeat(32'h44332211, 0, 0);
        pushBeat(32'h88776655, 0, 1);
        applyStimulus(100, 100, 3, 50, 1, cyc);
        checkChunk("s1 c0", 0, 32'h00332211, 3, 0);
        checkChunk("s1 c1", 1, 32'h00665544, 3, 0);
        checkChunk("s1 c2", 2, 32'h00008877, 2, 1);

        $display("[TB] single short beat");
        chunkLog.delete();
        pushBeat(32'h000000AB, 1, 1);
        applyStimulus(100, 100, 0, 50, 1, cyc);
        checkChunk("s2 c0", 0, 32'h000000AB, 1, 1);

        $display("[TB] request larger than remainder");
        chunkLog.delete();
        pushBeat(32'h04030201, 0, 0);
        pushBeat(32'h00000005, 1, 1);
        applyStimulus(100, 100, 2, 50, 1, cyc);
        checkChunk("s5 c0", 0, 32'h00000201, 2, 0);
        checkChunk("s5 c1", 1, 32'h00000403, 2, 0);
        checkChunk("s5 c2", 2, 32'h00000005, 1, 1);

        $display("[TB] full-rate streaming");
        chunkLog.delete();
        for (int b = 0; b < 8; b++) pushBeat({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, 0, b == 7);
        applyStimulus(100, 100, 0, 50, 1, cyc);
        checkField("s4 cycles", cyc, 9);
        checkChunk("s4 c0", 0, 32'h03020100, 0, 0);
        checkChunk("s4 c7", 7, 32'h1F1E1D1C, 0, 1);

        $display("[TB] consumer stall");
        chunkLog.delete();
        pushBeat(32'h04030201, 0, 0);
        pushBeat(32'h08070605, 0, 0);
        pushBeat(32'h0C0B0A09, 0, 1);
        applyStimulus(100, 0, 0, 4, 0, cyc);
        #1;
        checkField("s3 in_ready", bus.in_ready, 0);
        checkField("s3 depth", mq.size(), 8);
        checkField("s3 out_data", bus.out_data, 32'h04030201);
        step();
        #1;
        checkField("s3 out_data held", bus.out_data, 32'h04030201);
        applyStimulus(100, 100, 0, 50, 1, cyc);
        checkChunk("s3 c0", 0, 32'h04030201, 0, 0);
        checkChunk("s3 c1", 1, 32'h08070605, 0, 0);
        checkChunk("s3 c2", 2, 32'h0C0B0A09, 0, 1);

        $display("[TB] reset mid-packet");
        chunkLog.delete();
        pushBeat(32'h00CCBBAA, 3, 1);
        applyStimulus(100, 0, 0, 3, 0, cyc);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checkField("s6 out_valid", bus.out_valid, 0);
        checkField("s6 in_ready", bus.in_ready, 1);
        checkField("s6 depth", mq.size(), 0);
        pushBeat(32'hDDCCBBAA, 0, 1);
        applyStimulus(100, 100, 0, 50, 1, cyc);
        checkChunk("s6 c0", 0, 32'hDDCCBBAA, 0, 1);
        checkField("s6 chunks", chunkLog.size(), 1);

        $display("[TB] random packets");
        for (int pass = 0; pass < 2; pass++) begin
            for (int p = 0; p < 120; p++) begin
                int len = $urandom_range(1, 12);
                for (int off = 0; off < len; off += DB) begin
                    int n = (len - off < DB) ? len - off : DB;
                    pushBeat($urandom, (n == DB) ? 0 : n, (off + n) >= len);
                end
            end
            applyStimulus(pass == 0 ? 70 : 100, pass == 0 ? 60 : 100, -1, 20000, 1, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
